// File: rtl/sat_add_pkg.sv
// Shared definitions for the saturating-add arbiter slice.
//   sat_max / sat_min : two's-complement clamp limits for a given width
//   id_width          : requester index width, clog2(n) with a floor of 1
//   req_idx_t         : requester index type sized for the largest legal N_REQ
package sat_add_pkg;

  localparam int unsigned MAX_WIDTH = 16;
  localparam int unsigned MAX_REQ   = 4;
  localparam int unsigned MAX_ID_W  = 2;

  typedef logic [MAX_ID_W-1:0] req_idx_t;

  // Largest positive value, 0111..1, right-aligned in MAX_WIDTH bits.
  function automatic logic [MAX_WIDTH-1:0] sat_max(input int unsigned width);
    return MAX_WIDTH'((32'd1 << (width - 32'd1)) - 32'd1);
  endfunction

  // Most negative value, 1000..0, right-aligned in MAX_WIDTH bits.
  function automatic logic [MAX_WIDTH-1:0] sat_min(input int unsigned width);
    return MAX_WIDTH'(32'd1 << (width - 32'd1));
  endfunction

  function automatic int unsigned id_width(input int unsigned n);
    return (n < 32'd2) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/sat_add_core.sv
// Combinational signed saturating adder.
//   a, b : two's-complement operands, WIDTH bits
//   sum  : a + b clamped to [MIN, MAX]
//   sat  : 1 when the result was clamped
module sat_add_core
  import sat_add_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             sat
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(sat_min(WIDTH));

  logic [WIDTH:0] ext_sum;

  assign ext_sum = {a[WIDTH-1], a} + {b[WIDTH-1], b};

  // The top two bits of the sign-extended sum disagree exactly when the
  // operands share a sign and the truncated sum flips it; bit WIDTH is the
  // true sign and picks the clamp direction.
  always_comb begin
    sat = ext_sum[WIDTH] ^ ext_sum[WIDTH-1];
    sum = ext_sum[WIDTH-1:0];
    if (sat) begin
      sum = ext_sum[WIDTH] ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/sat_add_arbiter.sv
// Round-robin arbiter sharing one signed saturating adder among N_REQ
// requesters, with a single-entry registered result stage.
//   clk, rst          : clock, asynchronous active-high reset
//   req_vld/req_rdy   : per-requester handshake; req_rdy is one-hot or zero
//   req_a, req_b      : per-requester signed operands
//   res_vld/res_rdy   : result handshake
//   res_sum, res_id   : saturated sum and index of the producing requester
//   res_sat           : result was clamped
//   sat_cnt           : saturating count of clamped accepts
//                       (only with SAT_ADD_ARB_SAT_CNT_EN defined)
module sat_add_arbiter
  import sat_add_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned N_REQ = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_vld,
  input  logic [N_REQ-1:0][WIDTH-1:0]   req_a,
  input  logic [N_REQ-1:0][WIDTH-1:0]   req_b,
  output logic [N_REQ-1:0]              req_rdy,
  output logic                          res_vld,
  input  logic                          res_rdy,
  output logic [WIDTH-1:0]              res_sum,
  output logic [id_width(N_REQ)-1:0]    res_id,
  output logic                          res_sat
`ifdef SAT_ADD_ARB_SAT_CNT_EN
 ,output logic [7:0]                    sat_cnt
`endif
);

  localparam int unsigned ID_W = id_width(N_REQ);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [ID_W-1:0]  rr_q, rr_d;
  logic [ID_W-1:0]  win_idx;
  logic             win_found;
  logic             can_accept;
  logic             accept;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [WIDTH-1:0] add_sum;
  logic             add_sat;

  assign res_vld    = (state_q == S_FULL);
  assign can_accept = !res_vld || res_rdy;

  // Round-robin search: first pass covers indices rr..N_REQ-1, second pass
  // wraps to 0..rr-1. The earliest set bit in that order wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_found && req_vld[i] && (ID_W'(i) >= rr_q)) begin
        win_found = 1'b1;
        win_idx   = ID_W'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_found && req_vld[i]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(i);
      end
    end
  end

  // No grant while reset is held, so nothing handshakes in the reset cycle.
  assign accept = win_found && can_accept && !rst;

  always_comb begin
    req_rdy = '0;
    if (accept) begin
      req_rdy[win_idx] = 1'b1;
    end
  end

  assign sel_a = req_a[win_idx];
  assign sel_b = req_b[win_idx];

  sat_add_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a   (sel_a),
    .b   (sel_b),
    .sum (add_sum),
    .sat (add_sat)
  );

  // Output-stage FSM and round-robin pointer next state.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    if (accept) begin
      rr_d = (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + ID_W'(1);
    end
    unique case (state_q)
      S_EMPTY: if (accept)              state_d = S_FULL;
      S_FULL:  if (res_rdy && !accept)  state_d = S_EMPTY;
      default:                          state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_EMPTY;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
    end
  end

  // Result payload only loads on accept, so it holds steady under back-pressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_sum <= '0;
      res_id  <= '0;
      res_sat <= 1'b0;
    end else if (accept) begin
      res_sum <= add_sum;
      res_id  <= win_idx;
      res_sat <= add_sat;
    end
  end

`ifdef SAT_ADD_ARB_SAT_CNT_EN
  // Counts clamped accepts, sticking at 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_cnt <= 8'd0;
    end else if (accept && add_sat && (sat_cnt != 8'hFF)) begin
      sat_cnt <= sat_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sat_add_arbiter.sv
// Scoreboard bench for sat_add_arbiter (WIDTH=4, N_REQ=2): stimulus pushes
// hand-computed results, a negedge monitor pops on each result handshake.
module tb_sat_add_arbiter;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned N_REQ = 2;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [N_REQ-1:0]            req_vld;
  logic [N_REQ-1:0][WIDTH-1:0] req_a;
  logic [N_REQ-1:0][WIDTH-1:0] req_b;
  logic [N_REQ-1:0]            req_rdy;
  logic                        res_vld;
  logic                        res_rdy;
  logic [WIDTH-1:0]            res_sum;
  logic [0:0]                  res_id;
  logic                        res_sat;
`ifdef SAT_ADD_ARB_SAT_CNT_EN
  logic [7:0]                  sat_cnt;
`endif

  typedef struct packed {
    logic [0:0] id;
    logic [3:0] sum;
    logic       sat;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  sat_add_arbiter #(
    .WIDTH (WIDTH),
    .N_REQ (N_REQ)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req_vld (req_vld),
    .req_a   (req_a),
    .req_b   (req_b),
    .req_rdy (req_rdy),
    .res_vld (res_vld),
    .res_rdy (res_rdy),
    .res_sum (res_sum),
    .res_id  (res_id),
    .res_sat (res_sat)
`ifdef SAT_ADD_ARB_SAT_CNT_EN
   ,.sat_cnt (sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [0:0] id, input logic [3:0] sum, input logic sat);
    exp_t e;
    e.id  = id;
    e.sum = sum;
    e.sat = sat;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: one pop per result handshake, compared field by field.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && res_vld && res_rdy) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got id=%0d sum=%0h sat=%0d, required none",
                 res_id, res_sum, res_sat);
      end else begin
        e = exp_q.pop_front();
        chk("res_id",  32'(res_id),  32'(e.id));
        chk("res_sum", 32'(res_sum), 32'(e.sum));
        chk("res_sat", 32'(res_sat), 32'(e.sat));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  // Single-requester vectors: a, b, expected sum, expected sat.
  logic [3:0] va [7] = '{4'h3, 4'h7, 4'h8, 4'h8, 4'hD, 4'h4, 4'h0};
  logic [3:0] vb [7] = '{4'h2, 4'h1, 4'hF, 4'h7, 4'hC, 4'h4, 4'h0};
  logic [3:0] vs [7] = '{4'h5, 4'h7, 4'h8, 4'hF, 4'h9, 4'h7, 4'h0};
  logic       vt [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    rst     = 1'b1;
    req_vld = 2'b11;
    req_a   = '0;
    req_b   = '0;
    res_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res_vld", 32'(res_vld), 32'd0);
    chk("rst_res_sum", 32'(res_sum), 32'd0);
    chk("rst_res_id",  32'(res_id),  32'd0);
    chk("rst_res_sat", 32'(res_sat), 32'd0);
    chk("rst_req_rdy", 32'(req_rdy), 32'd0);
    req_vld = 2'b00;
    rst     = 1'b0;
    step();

    // Requester 0 alone, one op per cycle, arithmetic corners.
    res_rdy = 1'b1;
    for (int i = 0; i < 7; i++) begin
      req_vld  = 2'b01;
      req_a[0] = va[i];
      req_b[0] = vb[i];
      #1;
      chk("single_req_rdy", 32'(req_rdy), 32'd1);
      push(1'b0, vs[i], vt[i]);
      step();
    end
    req_vld = 2'b00;

    // Requester 1 alone: 1 + 1; moves pointer back to 0.
    req_vld  = 2'b10;
    req_a[1] = 4'h1;
    req_b[1] = 4'h1;
    #1;
    chk("req1_req_rdy", 32'(req_rdy), 32'd2);
    push(1'b1, 4'h2, 1'b0);
    step();

    // Both requesting for 6 cycles: grants alternate 0,1,0,1,0,1.
    req_vld  = 2'b11;
    req_a[0] = 4'h1;
    req_b[0] = 4'h2;
    req_a[1] = 4'hE;
    req_b[1] = 4'hD;
    for (int i = 0; i < 6; i++) begin
      #1;
      if ((i % 2) == 0) begin
        chk("rr_req_rdy", 32'(req_rdy), 32'd1);
        push(1'b0, 4'h3, 1'b0);
      end else begin
        chk("rr_req_rdy", 32'(req_rdy), 32'd2);
        push(1'b1, 4'hB, 1'b0);
      end
      step();
    end
    req_vld = 2'b00;
    #1;
    chk("idle_req_rdy", 32'(req_rdy), 32'd0);
    step();

    // Back-pressure: result held for 3 cycles, then drain + accept together.
    res_rdy  = 1'b0;
    req_vld  = 2'b01;
    req_a[0] = 4'h2;
    req_b[0] = 4'h2;
    #1;
    chk("bp_first_req_rdy", 32'(req_rdy), 32'd1);
    push(1'b0, 4'h4, 1'b0);
    step();
    req_vld  = 2'b11;
    req_a[0] = 4'h5;
    req_b[0] = 4'h5;
    req_a[1] = 4'hF;
    req_b[1] = 4'hF;
    for (int i = 0; i < 3; i++) begin
      chk("bp_res_vld", 32'(res_vld), 32'd1);
      chk("bp_res_sum", 32'(res_sum), 32'h4);
      chk("bp_res_id",  32'(res_id),  32'd0);
      chk("bp_res_sat", 32'(res_sat), 32'd0);
      chk("bp_req_rdy", 32'(req_rdy), 32'd0);
      step();
    end
    res_rdy = 1'b1;
    #1;
    chk("bp_release_req_rdy", 32'(req_rdy), 32'd2);
    push(1'b1, 4'hE, 1'b0);
    step();
    #1;
    chk("bp_next_req_rdy", 32'(req_rdy), 32'd1);
    push(1'b0, 4'h7, 1'b1);
    step();
    req_vld = 2'b00;
    step();

    // Async reset while a result is pending; pointer was 1 before reset.
    res_rdy  = 1'b0;
    req_vld  = 2'b01;
    req_a[0] = 4'h1;
    req_b[0] = 4'h0;
    step();
    req_vld = 2'b11;
    #1;
    chk("pre_rst_res_vld", 32'(res_vld), 32'd1);
    chk("pre_rst_req_rdy", 32'(req_rdy), 32'd0);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_res_vld", 32'(res_vld), 32'd0);
    chk("mid_rst_res_sum", 32'(res_sum), 32'd0);
    chk("mid_rst_res_id",  32'(res_id),  32'd0);
    chk("mid_rst_req_rdy", 32'(req_rdy), 32'd0);
    step();
    chk("hold_rst_req_rdy", 32'(req_rdy), 32'd0);
    rst      = 1'b0;
    res_rdy  = 1'b1;
    req_a[0] = 4'h2;
    req_b[0] = 4'h3;
    req_a[1] = 4'h3;
    req_b[1] = 4'hF;
    #1;
    chk("post_rst_req_rdy", 32'(req_rdy), 32'd1);
    push(1'b0, 4'h5, 1'b0);
    step();
    req_vld = 2'b10;
    #1;
    chk("post_rst_req1_rdy", 32'(req_rdy), 32'd2);
    push(1'b1, 4'h2, 1'b0);
    step();
    req_vld = 2'b00;
    step();

`ifdef SAT_ADD_ARB_SAT_CNT_EN
    // Saturation counter: 300 clamped ops stick at 255; clean ops leave it.
    chk("sat_cnt_after_rst", 32'(sat_cnt), 32'd0);
    req_vld  = 2'b01;
    req_a[0] = 4'h7;
    req_b[0] = 4'h7;
    for (int i = 0; i < 100; i++) begin
      push(1'b0, 4'h7, 1'b1);
      step();
    end
    chk("sat_cnt_100", 32'(sat_cnt), 32'd100);
    for (int i = 0; i < 200; i++) begin
      push(1'b0, 4'h7, 1'b1);
      step();
    end
    chk("sat_cnt_300", 32'(sat_cnt), 32'd255);
    req_a[0] = 4'h1;
    req_b[0] = 4'h1;
    for (int i = 0; i < 5; i++) begin
      push(1'b0, 4'h2, 1'b0);
      step();
    end
    chk("sat_cnt_clean", 32'(sat_cnt), 32'd255);
    req_vld = 2'b00;
`endif

    repeat (3) step();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
